// File: rtl/if_id_buf.sv
// IF/ID stage buffer: DEPTH-entry FIFO carrying {pc, inst} from the IFU to the IDU.
// Optional zero-latency pass-through when empty is enabled by defining IF_ID_BYPASS_EN.
module if_id_buf #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              f_valid_i,
  input  logic [INST_W-1:0] f_inst_i,
  input  logic [PC_W-1:0]   f_pc_i,
  output logic              D_ready_o,
  output logic              d_valid_o,
  output logic [INST_W-1:0] d_inst_o,
  output logic [PC_W-1:0]   d_pc_o,
  input  logic              d_ready_i,
  input  logic              flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic empty;
  logic bypass;
  logic push;
  logic pop;

  // Power-of-two depth lets the pointer wrap by plain overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] c,
                                                  input logic do_push,
                                                  input logic do_pop);
    logic [CNT_W-1:0] n;
    n = c;
    if (do_push && !do_pop) n = c + CNT_W'(1);
    else if (do_pop && !do_push) n = c - CNT_W'(1);
    return n;
  endfunction

  assign empty     = (count == '0);
  // Ready depends only on the registered occupancy.
  assign D_ready_o = (count != FULL_CNT);
  assign count_o   = count;

  always_comb begin
    bypass = 1'b0;
`ifdef IF_ID_BYPASS_EN
    bypass = empty && f_valid_i && d_ready_i && !flush_i;
`endif
    push      = f_valid_i && D_ready_o && !flush_i && !bypass;
    pop       = !empty && !flush_i && d_ready_i;
    d_valid_o = (!empty || bypass) && !flush_i;
    d_inst_o  = inst_mem[rd_ptr];
    d_pc_o    = pc_mem[rd_ptr];
    if (bypass) begin
      d_inst_o = f_inst_i;
      d_pc_o   = f_pc_i;
    end
  end

  // Control state: occupancy and pointers; flush outranks push/pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_i) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_next(count, push, pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Storage: pc and inst always written together into one slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]   <= f_pc_i;
      inst_mem[wr_ptr] <= f_inst_i;
    end
  end

endmodule
